// File: rtl/sccb_arb_pkg.sv
// Shared types and constants for the SCCB write arbiter.
// In-band command codes are matched against the {reg_addr, data} pair of a request.
package sccb_arb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitDone,
    StDelay,
    StResp,
    StGap
  } state_e;

  localparam logic [15:0] CMD_DELAY     = 16'hFFF0;
  localparam logic [15:0] CMD_END       = 16'hFFFF;
  localparam logic [7:0]  SCCB_SLAVE_WR = 8'h42;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sccb_rr_arbiter.sv
// Combinational rotate-priority picker: first valid requester after i_rr_ptr, wrapping.
// The pointer itself is owned by the parent.
module sccb_rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IdxW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req_valid,
  input  logic [IdxW-1:0]    i_rr_ptr,
  output logic [NUM_REQ-1:0] o_grant_onehot,
  output logic [IdxW-1:0]    o_grant_idx,
  output logic               o_any_valid
);

  logic [IdxW-1:0] w_j;

  always_comb begin
    o_any_valid = 1'b0;
    o_grant_idx = '0;
    w_j         = '0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      w_j = IdxW'((int'(i_rr_ptr) + k) % int'(NUM_REQ));
      if (!o_any_valid && i_req_valid[w_j]) begin
        o_any_valid = 1'b1;
        o_grant_idx = w_j;
      end
    end
  end

  assign o_grant_onehot = o_any_valid ? (NUM_REQ'(1) << o_grant_idx) : '0;

endmodule

// File: rtl/sccb_write_arbiter.sv
// Round-robin sharing of one SCCB write master, with local DELAY/END command handling.
// Optional sccb_done watchdog enabled by defining SCCB_ARB_TIMEOUT_EN.
module sccb_write_arbiter
  import sccb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter logic [7:0]  SLAVE_ADDR     = SCCB_SLAVE_WR,
  parameter int unsigned GAP_CYCLES     = 100,
  parameter int unsigned DELAY_CYCLES   = 10000,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [NUM_REQ*8-1:0]       i_req_reg_addr,
  input  logic [NUM_REQ*8-1:0]       i_req_data,
  output logic [NUM_REQ-1:0]         o_req_ready,
  output logic [NUM_REQ-1:0]         o_rsp_done,
  output logic [NUM_REQ-1:0]         o_rsp_err,
  output logic                       o_sccb_start,
  output logic [23:0]                o_sccb_indata,
  input  logic                       i_sccb_done,
  output logic                       o_busy,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_id
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(max3(GAP_CYCLES, DELAY_CYCLES, TIMEOUT_CYCLES) + 1);

  state_e              r_state, w_state_d;
  logic [CntW-1:0]     r_cnt, w_cnt_d;
  logic [IdxW-1:0]     r_grant, r_ptr;
  logic [NUM_REQ-1:0]  r_grant_oh;
  logic [23:0]         r_indata;
  logic [NUM_REQ-1:0]  w_grant_oh;
  logic [IdxW-1:0]     w_grant_idx;
  logic                w_any_valid;
  logic                w_is_cmd;

  sccb_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IdxW    (IdxW)
  ) u_rr (
    .i_req_valid    (i_req_valid),
    .i_rr_ptr       (r_ptr),
    .o_grant_onehot (w_grant_oh),
    .o_grant_idx    (w_grant_idx),
    .o_any_valid    (w_any_valid)
  );

  assign w_is_cmd = (r_indata[15:0] == CMD_DELAY) || (r_indata[15:0] == CMD_END);

`ifdef SCCB_ARB_TIMEOUT_EN
  logic r_err;
  logic w_timeout;

  assign w_timeout = (r_state == StWaitDone) && !i_sccb_done &&
                     (r_cnt == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (r_state == StIdle) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_ptr      <= IdxW'(NUM_REQ - 1);
      r_grant    <= '0;
      r_grant_oh <= '0;
      r_indata   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      if (r_state == StIdle && w_any_valid) begin
        r_grant    <= w_grant_idx;
        r_ptr      <= w_grant_idx;
        r_grant_oh <= w_grant_oh;
        r_indata   <= {SLAVE_ADDR, i_req_reg_addr[int'(w_grant_idx)*8 +: 8],
                       i_req_data[int'(w_grant_idx)*8 +: 8]};
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_any_valid) w_state_d = StIssue;
      end
      StIssue: begin
        w_cnt_d = '0;
        if (r_indata[15:0] == CMD_DELAY)    w_state_d = StDelay;
        else if (r_indata[15:0] == CMD_END) w_state_d = StResp;
        else                                w_state_d = StWaitDone;
      end
      StWaitDone: begin
        if (i_sccb_done) begin
          w_state_d = StResp;
`ifdef SCCB_ARB_TIMEOUT_EN
        end else if (w_timeout) begin
          w_state_d = StResp;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
`endif
        end
      end
      StDelay: begin
        // Holds one extra settle cycle after the 0..DELAY_CYCLES-1 count.
        if (r_cnt == CntW'(DELAY_CYCLES)) w_state_d = StResp;
        else                              w_cnt_d   = r_cnt + 1'b1;
      end
      StResp: begin
        w_cnt_d   = '0;
        w_state_d = StGap;
      end
      StGap: begin
        if (r_cnt == CntW'(GAP_CYCLES - 1)) begin
          w_state_d = StIdle;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    o_req_ready  = '0;
    o_rsp_done   = '0;
    o_rsp_err    = '0;
    o_sccb_start = 1'b0;
    if (r_state == StIssue) begin
      o_req_ready  = r_grant_oh;
      o_sccb_start = !w_is_cmd;
    end
    if (r_state == StResp) begin
      o_rsp_done = r_grant_oh;
`ifdef SCCB_ARB_TIMEOUT_EN
      if (r_err) o_rsp_err = r_grant_oh;
`endif
    end
  end

  assign o_sccb_indata = r_indata;
  assign o_busy        = (r_state != StIdle);
  assign o_grant_id    = r_grant;

endmodule

// File: tb/tb_sccb_write_arbiter.sv
// Directed bench for sccb_write_arbiter: scoreboard of expected start payloads plus timing checks.
// Covers the SCCB_ARB_TIMEOUT_EN build and the default build.
module tb_sccb_write_arbiter;

  localparam int unsigned GAP     = 100;
  localparam int unsigned DELAY   = 10000;
  localparam int unsigned TIMEOUT = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  i_req_valid;
  logic [15:0] i_req_reg_addr;
  logic [15:0] i_req_data;
  logic [1:0]  o_req_ready;
  logic [1:0]  o_rsp_done;
  logic [1:0]  o_rsp_err;
  logic        o_sccb_start;
  logic [23:0] o_sccb_indata;
  logic        i_sccb_done;
  logic        o_busy;
  logic [0:0]  o_grant_id;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  sccb_write_arbiter #(
    .NUM_REQ        (2),
    .SLAVE_ADDR     (8'h42),
    .GAP_CYCLES     (GAP),
    .DELAY_CYCLES   (DELAY),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .i_req_valid    (i_req_valid),
    .i_req_reg_addr (i_req_reg_addr),
    .i_req_data     (i_req_data),
    .o_req_ready    (o_req_ready),
    .o_rsp_done     (o_rsp_done),
    .o_rsp_err      (o_rsp_err),
    .o_sccb_start   (o_sccb_start),
    .o_sccb_indata  (o_sccb_indata),
    .i_sccb_done    (i_sccb_done),
    .o_busy         (o_busy),
    .o_grant_id     (o_grant_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every start pulse must match the oldest expected {id, indata}.
  always @(negedge clk) begin
    if (o_sccb_start) begin
      if (exp_q.size() == 0) begin
        check("unexpected_start", {7'b0, o_grant_id, o_sccb_indata}, 32'hDEADBEEF);
      end else begin
        check("start_payload", {7'b0, o_grant_id, o_sccb_indata}, exp_q.pop_front());
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic v, input logic [7:0] a, input logic [7:0] d);
    i_req_valid[i]          = v;
    i_req_reg_addr[i*8 +: 8] = a;
    i_req_data[i*8 +: 8]     = d;
  endtask

  task automatic wait_ready(input string tag, input logic [1:0] exp_oh);
    int n;
    n = 0;
    while (o_req_ready == 2'b00 && n < 400) begin
      cyc();
      n++;
    end
    check(tag, 32'(o_req_ready), 32'(exp_oh));
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    cyc();
    n = 1;
    while (o_rsp_done == 2'b00 && n < 20000) begin
      cyc();
      n++;
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    cyc();
    while (o_busy && n < 20000) begin
      n++;
      cyc();
    end
  endtask

  task automatic pulse_done();
    i_sccb_done = 1'b1;
    cyc();
    i_sccb_done = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {o_req_ready, o_rsp_done, o_rsp_err, 1'b0, o_sccb_start, o_busy, o_grant_id,
                o_sccb_indata}, 32'h0);
  endtask

  initial begin
    int n;
    int bad;
    logic [1:0] oh;
    reset          = 1'b1;
    i_req_valid    = '0;
    i_req_reg_addr = '0;
    i_req_data     = '0;
    i_sccb_done    = 1'b0;
    repeat (3) cyc();
    check_all_zero("reset_outputs");
    reset = 1'b0;
    cyc();

    // Single write
    exp_q.push_back(32'h00_421280);
    set_req(0, 1'b1, 8'h12, 8'h80);
    wait_ready("t1_ready", 2'b01);
    check("t1_start", 32'(o_sccb_start), 32'd1);
    check("t1_indata", 32'(o_sccb_indata), 32'h421280);
    check("t1_grant", 32'(o_grant_id), 32'd0);
    set_req(0, 1'b0, 8'h00, 8'h00);
    cyc();
    check("t1_start_width", 32'(o_sccb_start), 32'd0);
    check("t1_indata_hold", 32'(o_sccb_indata), 32'h421280);
    cyc();
    pulse_done();
    check("t1_rsp_done", 32'(o_rsp_done), 32'h1);
    check("t1_rsp_err", 32'(o_rsp_err), 32'h0);
    wait_idle(n);
    check("t1_gap_len", 32'(n), 32'(GAP));

    // Contention after reset: 0,1,0,1
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
    exp_q.push_back(32'h00_4210A0);
    exp_q.push_back(32'h01_4220B0);
    exp_q.push_back(32'h00_4211A1);
    exp_q.push_back(32'h01_4221B1);
    set_req(0, 1'b1, 8'h10, 8'hA0);
    set_req(1, 1'b1, 8'h20, 8'hB0);
    for (int k = 0; k < 4; k++) begin
      oh = 2'b01 << (k % 2);
      wait_ready($sformatf("t2_ready_%0d", k), oh);
      check($sformatf("t2_grant_%0d", k), 32'(o_grant_id), 32'(k % 2));
      if (k < 2) set_req(k % 2, 1'b1, 8'h11 + 8'(16 * (k % 2)), 8'hA1 + 8'(16 * (k % 2)));
      else       set_req(k % 2, 1'b0, 8'h00, 8'h00);
      cyc();
      cyc();
      pulse_done();
      check($sformatf("t2_rsp_%0d", k), 32'(o_rsp_done), 32'(oh));
      wait_idle(n);
    end

    // DELAY command on requester 1
    set_req(1, 1'b1, 8'hFF, 8'hF0);
    wait_ready("t3_ready", 2'b10);
    check("t3_no_start", 32'(o_sccb_start), 32'd0);
    set_req(1, 1'b0, 8'h00, 8'h00);
    wait_rsp(n);
    check("t3_delay_len", 32'(n), 32'(DELAY + 2));
    check("t3_rsp_done", 32'(o_rsp_done), 32'h2);
    wait_idle(n);

    // END command on requester 0
    set_req(0, 1'b1, 8'hFF, 8'hFF);
    wait_ready("t4_ready", 2'b01);
    check("t4_no_start", 32'(o_sccb_start), 32'd0);
    set_req(0, 1'b0, 8'h00, 8'h00);
    wait_rsp(n);
    check("t4_end_len", 32'(n), 32'd1);
    check("t4_rsp_done", 32'(o_rsp_done), 32'h1);
    wait_idle(n);

    // Reset while waiting for sccb_done
    exp_q.push_back(32'h01_423344);
    set_req(1, 1'b1, 8'h33, 8'h44);
    wait_ready("t5_ready", 2'b10);
    set_req(1, 1'b0, 8'h00, 8'h00);
    cyc();
    cyc();
    check("t5_busy_before", 32'(o_busy), 32'd1);
    reset = 1'b1;
    #1;
    check_all_zero("t5_reset_outputs");
    cyc();
    reset = 1'b0;
    cyc();
    pulse_done();
    check("t5_stale_done", {30'b0, o_rsp_done}, 32'h0);
    check("t5_stale_busy", 32'(o_busy), 32'd0);
    exp_q.push_back(32'h00_427788);
    set_req(0, 1'b1, 8'h77, 8'h88);
    set_req(1, 1'b1, 8'h99, 8'hAA);
    wait_ready("t5_regrant", 2'b01);
    set_req(0, 1'b0, 8'h00, 8'h00);
    set_req(1, 1'b0, 8'h00, 8'h00);
    cyc();
    pulse_done();
    check("t5_rsp_done", 32'(o_rsp_done), 32'h1);
    wait_idle(n);

    // sccb_done never arrives
    exp_q.push_back(32'h00_425566);
    set_req(0, 1'b1, 8'h55, 8'h66);
    wait_ready("t6_ready", 2'b01);
    set_req(0, 1'b0, 8'h00, 8'h00);
`ifdef SCCB_ARB_TIMEOUT_EN
    wait_rsp(n);
    check("t6_timeout_len", 32'(n), 32'(TIMEOUT + 1));
    check("t6_rsp_done", 32'(o_rsp_done), 32'h1);
    check("t6_rsp_err", 32'(o_rsp_err), 32'h1);
    wait_idle(n);
`else
    bad = 0;
    repeat (TIMEOUT + 100) begin
      cyc();
      if (!o_busy || o_rsp_done != 2'b00 || o_rsp_err != 2'b00) bad++;
    end
    check("t6_busy_held", 32'(bad), 32'd0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
`endif

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
